// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_prefix_adder
// Purpose  : Kogge-Stone add/subtract with STAGES register ranks under one
//            global valid/ready stall. Define PPA_OVF_EN to add the ovf port.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_prefix_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PPA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_levels = $clog2(WIDTH);

  // Boundary 0 sits after operand prep, boundary j after prefix level j.
  // Rank 1 is boundary 0; middle ranks are spread evenly over 1..c_levels-1.
  function automatic logic [c_levels:0] rank_mask();
    logic [c_levels:0] m;
    m = '0;
    if (STAGES > 1) begin
      m[0] = 1'b1;
      for (int k = 1; k <= STAGES - 2; k++) begin
        m[(k * c_levels) / (STAGES - 1)] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [c_levels:0] c_rank = rank_mask();

  logic w_adv;

  logic [c_levels:0][WIDTH-1:0] w_dx, w_db, w_dg, w_dp;
  logic [c_levels:0]            w_dc0, w_dv;
  logic [c_levels:0][WIDTH-1:0] r_x, r_b, r_g, r_p;
  logic [c_levels:0]            r_c0, r_v;

  logic [WIDTH-1:0] w_vx, w_vb, w_vg, w_vp, w_ng, w_np, w_sum;
  logic             w_vc0, w_vv, w_cout;

  logic [WIDTH-1:0] r_s;
  logic             r_cout, r_out_valid;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;

  // Walks the datapath boundary by boundary; a ranked boundary exposes its
  // next-state on w_d* and continues from the registered copy.
  always_comb begin
    w_vx  = x;
    w_vb  = sub ? ~y : y;
    w_vc0 = sub | cin;
    w_vv  = in_valid;
    w_ng  = '0;
    w_np  = '0;
    w_dx  = '0;
    w_db  = '0;
    w_dg  = '0;
    w_dp  = '0;
    w_dc0 = '0;
    w_dv  = '0;

    w_dx[0]  = w_vx;
    w_db[0]  = w_vb;
    w_dc0[0] = w_vc0;
    w_dv[0]  = w_vv;
    if (c_rank[0]) begin
      w_vx  = r_x[0];
      w_vb  = r_b[0];
      w_vc0 = r_c0[0];
      w_vv  = r_v[0];
    end

    // Carry-in folded into bit 0 so G[i] ends up as the carry out of bit i.
    w_vp    = w_vx ^ w_vb;
    w_vg    = w_vx & w_vb;
    w_vg[0] = w_vg[0] | (w_vp[0] & w_vc0);

    for (int j = 1; j <= c_levels; j++) begin
      w_ng = w_vg;
      w_np = w_vp;
      for (int i = (1 << (j - 1)); i < WIDTH; i++) begin
        w_ng[i] = w_vg[i] | (w_vp[i] & w_vg[i - (1 << (j - 1))]);
        w_np[i] = w_vp[i] & w_vp[i - (1 << (j - 1))];
      end
      w_vg = w_ng;
      w_vp = w_np;

      w_dx[j]  = w_vx;
      w_db[j]  = w_vb;
      w_dg[j]  = w_vg;
      w_dp[j]  = w_vp;
      w_dc0[j] = w_vc0;
      w_dv[j]  = w_vv;
      if (c_rank[j]) begin
        w_vx  = r_x[j];
        w_vb  = r_b[j];
        w_vg  = r_g[j];
        w_vp  = r_p[j];
        w_vc0 = r_c0[j];
        w_vv  = r_v[j];
      end
    end

    w_sum  = (w_vx ^ w_vb) ^ {w_vg[WIDTH-2:0], w_vc0};
    w_cout = w_vg[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_b  <= '0;
      r_g  <= '0;
      r_p  <= '0;
      r_c0 <= '0;
      r_v  <= '0;
    end else if (w_adv) begin
      for (int j = 0; j <= c_levels; j++) begin
        if (c_rank[j]) begin
          r_x[j]  <= w_dx[j];
          r_b[j]  <= w_db[j];
          r_g[j]  <= w_dg[j];
          r_p[j]  <= w_dp[j];
          r_c0[j] <= w_dc0[j];
          r_v[j]  <= w_dv[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_s         <= w_sum;
      r_cout      <= w_cout;
      r_out_valid <= w_vv;
    end
  end

`ifdef PPA_OVF_EN
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = (w_vx[WIDTH-1] == w_vb[WIDTH-1]) && (w_sum[WIDTH-1] != w_vx[WIDTH-1]);
  assign ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
`default_nettype none
// Directed checks on three pipelined_prefix_adder configurations:
// A = 32-bit/3 ranks, B = 16-bit/1 rank, C = 8-bit/2 ranks.
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready, a_cout;
  logic [31:0] a_x, a_y, a_s;
  logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout;
  logic [15:0] b_x, b_y, b_s;
  logic        c_in_valid, c_in_ready, c_cin, c_sub, c_out_valid, c_out_ready, c_cout;
  logic [7:0]  c_x, c_y, c_s;
`ifdef PPA_OVF_EN
  logic        a_ovf, b_ovf, c_ovf;
`endif

  pipelined_prefix_adder #(.WIDTH(32), .STAGES(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .cin(a_cin), .sub(a_sub), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .s(a_s), .cout(a_cout)
`ifdef PPA_OVF_EN
    , .ovf(a_ovf)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(16), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .cin(b_cin), .sub(b_sub), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .s(b_s), .cout(b_cout)
`ifdef PPA_OVF_EN
    , .ovf(b_ovf)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(8), .STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .x(c_x), .y(c_y), .cin(c_cin), .sub(c_sub), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .s(c_s), .cout(c_cout)
`ifdef PPA_OVF_EN
    , .ovf(c_ovf)
`endif
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Hand-computed stream table: x, y, cin, sub -> s, cout
  logic [31:0] st_x [0:7] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                              32'h80000000, 32'h0000000A, 32'h7FFFFFFF, 32'hDEADBEEF};
  logic [31:0] st_y [0:7] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h11111111,
                              32'h80000000, 32'h0000000A, 32'h00000000, 32'h01010101};
  logic        st_ci[0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        st_sb[0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] st_s [0:7] = '{32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h01234567,
                              32'h00000000, 32'h00000000, 32'h80000000, 32'hDFAEBFF0};
  logic        st_c [0:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] xx, input logic [31:0] yy,
                         input logic ci, input logic sb);
    a_in_valid = v;
    a_x        = xx;
    a_y        = yy;
    a_cin      = ci;
    a_sub      = sb;
  endtask

  initial begin
    rst_n = 1'b1;
    drive_a(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_cin = 1'b0; b_sub = 1'b0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_x = '0; c_y = '0; c_cin = 1'b0; c_sub = 1'b0; c_out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;

    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_s", a_s, 0);
    check("rst_a_cout", a_cout, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_c_valid", c_out_valid, 0);

    // Operands offered while reset is held must never be captured
    drive_a(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    b_in_valid = 1'b1; c_in_valid = 1'b1;
    tick();
    tick();
    check("rst_hold_a_valid", a_out_valid, 0);
    check("rst_hold_b_valid", b_out_valid, 0);

    rst_n = 1'b1;
    #1;
    check("release_a_ready", a_in_ready, 1);

    drive_a(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
    b_in_valid = 1'b1; b_x = 16'hFFFF; b_y = 16'h0001; b_cin = 1'b0; b_sub = 1'b0;
    c_in_valid = 1'b1; c_x = 8'h7F; c_y = 8'h01; c_cin = 1'b0; c_sub = 1'b0;
    tick();
    check("b_valid", b_out_valid, 1);
    check("b_s", b_s, 16'h0000);
    check("b_cout", b_cout, 1);
    check("a_lat1_valid", a_out_valid, 0);
    check("c_lat1_valid", c_out_valid, 0);
    drive_a(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    b_in_valid = 1'b0; c_in_valid = 1'b0;
    tick();
    check("c_valid", c_out_valid, 1);
    check("c_s", c_s, 8'h80);
    check("c_cout", c_cout, 0);
`ifdef PPA_OVF_EN
    check("c_ovf", c_ovf, 1);
`endif
    check("b_bubble_valid", b_out_valid, 0);
    check("a_lat2_valid", a_out_valid, 0);
    tick();
    check("a_sub_valid", a_out_valid, 1);
    check("a_sub_s", a_s, 32'hFFFFFFFE);
    check("a_sub_cout", a_cout, 0);
`ifdef PPA_OVF_EN
    check("a_sub_ovf", a_ovf, 0);
`endif
    tick();
    check("a_sub_drain", a_out_valid, 0);

    // Back-to-back stream, results two edges behind captures
    for (int t = 0; t < 10; t++) begin
      if (t < 8) drive_a(1'b1, st_x[t], st_y[t], st_ci[t], st_sb[t]);
      else       drive_a(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check($sformatf("stream_ready%0d", t), a_in_ready, 1);
      tick();
      if (t >= 2) begin
        check($sformatf("stream_valid%0d", t - 2), a_out_valid, 1);
        check($sformatf("stream_s%0d", t - 2), a_s, st_s[t-2]);
        check($sformatf("stream_cout%0d", t - 2), a_cout, st_c[t-2]);
      end else begin
        check($sformatf("stream_empty%0d", t), a_out_valid, 0);
      end
    end
    tick();
    check("stream_drain", a_out_valid, 0);

    // Stall with a full pipeline
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h00000100, 32'h00000023, 1'b0, 1'b0);
    tick();
    check("stall_fill1", a_out_valid, 0);
    drive_a(1'b1, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
    tick();
    check("stall_fill2", a_out_valid, 0);
    drive_a(1'b1, 32'hF0000000, 32'h20000000, 1'b0, 1'b0);
    tick();
    check("stall_full_valid", a_out_valid, 1);
    check("stall_full_s", a_s, 32'h00000123);
    drive_a(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_ready%0d", k), a_in_ready, 0);
      tick();
      check($sformatf("stall_valid%0d", k), a_out_valid, 1);
      check($sformatf("stall_s%0d", k), a_s, 32'h00000123);
      check($sformatf("stall_cout%0d", k), a_cout, 0);
    end
    a_out_ready = 1'b1;
    #1;
    check("stall_release_ready", a_in_ready, 1);
    tick();
    drive_a(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("unstall_v2", a_out_valid, 1);
    check("unstall_s2", a_s, 32'hFFFFFFFF);
    check("unstall_c2", a_cout, 0);
    tick();
    check("unstall_v3", a_out_valid, 1);
    check("unstall_s3", a_s, 32'h10000000);
    check("unstall_c3", a_cout, 1);
    tick();
    check("unstall_v4", a_out_valid, 1);
    check("unstall_s4", a_s, 32'h00000000);
    check("unstall_c4", a_cout, 1);
    tick();
    check("unstall_drain", a_out_valid, 0);

    // Reset in the middle of a stream
    drive_a(1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    tick();
    check("midrst_pre_valid", a_out_valid, 1);
    check("midrst_pre_s", a_s, 32'd3);
    drive_a(1'b1, 32'd7, 32'd8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_async_valid", a_out_valid, 0);
    check("midrst_async_s", a_s, 0);
    check("midrst_async_ready", a_in_ready, 1);
    tick();
    check("midrst_held_valid", a_out_valid, 0);
    rst_n = 1'b1;
    drive_a(1'b1, 32'h00000040, 32'h00000002, 1'b0, 1'b0);
    tick();
    check("postrst_empty1", a_out_valid, 0);
    drive_a(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("postrst_empty2", a_out_valid, 0);
    tick();
    check("postrst_first_valid", a_out_valid, 1);
    check("postrst_first_s", a_s, 32'h00000042);
    check("postrst_first_cout", a_cout, 0);
    tick();
    check("postrst_drain", a_out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand/sum width in bits; legal 4..64.
REQ-002 Parameter: STAGES, 2, register ranks from input capture to output; legal 1..clog2(WIDTH)+1.
REQ-003 Port: clk  input  1  single clock, rising-edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  operands present.
REQ-006 Port: in_ready  output  1  block accepts operands this cycle.
REQ-007 Port: x, y  input  WIDTH  operands.
REQ-008 Port: cin  input  1  carry-in, used when sub=0.
REQ-009 Port: sub  input  1  0=add, 1=subtract.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: s  output  WIDTH  sum/difference.
REQ-013 Port: cout  output  1  carry-out (sub=1: 1 = no borrow).

Function
REQ-014 Arithmetic: b = sub ? ~y : y; c0 = sub ? 1 : cin; {cout,s} = x + b + c0, modulo 2^(WIDTH+1).
REQ-015 Carry network: parallel-prefix (generate/propagate) with clog2(WIDTH) combine levels; no ripple chain longer than one level.
REQ-016 Pipeline ranks: rank 1 captures x, b, c0 and sub; remaining STAGES-1 ranks are spread as evenly as possible over prefix levels, and the last rank holds s and cout.
REQ-017 Capture: transfer occurs on a rising edge where in_valid && in_ready.
REQ-018 Latency: with no stall, a result captured on edge k is on s/cout with out_valid=1 immediately after edge k+STAGES-1.
REQ-019 Throughput: one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-020 Global stall: adv = !out_valid || out_ready; in_ready = adv; all ranks, including valid bits, advance only when adv=1.
REQ-021 Bubbles: empty ranks advance like data; no bubble collapsing.
REQ-022 Hold: while out_valid=1 and out_ready=0, s, cout and out_valid are stable.
REQ-023 Simultaneous events: capture and output transfer on the same edge are both legal and both take effect.
REQ-024 in_valid=0 on an advancing edge inserts an empty rank; operand values are then don't-care.
REQ-025 Ordering: results emerge strictly in capture order; none are dropped or duplicated.

Reset
REQ-026 rst_n=0 asynchronously clears all rank valid bits; out_valid=0, s=0, cout=0 while rst_n=0.
REQ-027 in_ready=1 while rst_n=0 and on the first cycle after release; in-flight operands are discarded.
REQ-028 Reset release takes effect at the first rising edge after rst_n=1; no capture occurs at the release edge if rst_n is still 0 at that edge.

Configuration
REQ-029 Macro PPA_OVF_EN defined: output port ovf (1 bit) is added; ovf = (x[WIDTH-1]==b[WIDTH-1]) && (s[WIDTH-1]!=x[WIDTH-1]); ovf is pipelined alongside s, resets to 0 and holds under stall.
REQ-030 Macro PPA_OVF_EN undefined: no ovf port and no overflow logic.

Verification
REQ-031 WIDTH=16, STAGES=1: x=16'hFFFF, y=16'h0001, cin=0, sub=0 -> on the next cycle s=16'h0000, cout=1, out_valid=1.
REQ-032 WIDTH=32, STAGES=3: x=5, y=7, sub=1 -> after 3 cycles s=32'hFFFFFFFE, cout=0; ovf=0 if PPA_OVF_EN is defined.
REQ-033 Stream 8 random operand pairs back-to-back with out_ready=1 -> 8 consecutive out_valid cycles, each matching the reference model, in capture order.
REQ-034 Hold out_ready=0 for 4 cycles with the pipeline full -> in_ready=0, outputs stable; release -> no loss or duplication.
REQ-035 Assert rst_n=0 mid-stream with 2 results in flight -> out_valid=0 immediately; after release the next output is the first post-reset capture.
REQ-036 PPA_OVF_EN defined, WIDTH=8: x=8'h7F, y=8'h01, sub=0, cin=0 -> s=8'h80, ovf=1, cout=0.
